// File: rtl/led_pattern_gen.sv
// Status-LED effect generator (off/solid/blink/breathe) feeding the WS2812B serializer's GRB input.
// color_out is registered 1 cycle after level/base_color; no backpressure, the output may change any cycle.
module led_pattern_gen #(
    parameter int CLK_HZ      = 27000000,
    parameter int TICK_HZ     = 1000,
    parameter int BLINK_TICKS = 250,
    parameter int STEP        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [23:0] base_color,
    output logic [23:0] color_out,
    output logic [7:0]  level,
    output logic        tick
);

    localparam int         DIV    = CLK_HZ / TICK_HZ;
    localparam int         CNT_W  = $clog2(DIV);
    localparam int         BLK_W  = $clog2(BLINK_TICKS + 1);
    localparam logic [7:0] STEP_B = 8'(STEP);
    localparam logic [7:0] FULL   = 8'hFF;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    mode_e             mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              phase_q, phase_d;   // 1 = ON
    logic              dir_q, dir_d;       // 1 = DOWN
    logic [7:0]        level_q, level_d;
    logic [23:0]       color_q, color_d;
    logic              change;
    logic              cnt_end;
    logic              tick_w;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] l);
        logic [15:0] prod;
        prod = c * l;
        return (l == FULL) ? c : prod[15:8];
    endfunction

    always_comb begin
        mode_d  = mode_e'(mode);
        change  = (mode_d != mode_q);
        cnt_end = (cnt_q == CNT_W'(DIV - 1));
        tick_w  = cnt_end && !change;

        cnt_d   = (change || cnt_end) ? '0 : cnt_q + CNT_W'(1);
        blk_d   = blk_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        level_d = level_q;

        if (change) begin
            // A mode change overrides any tick landing in the same cycle.
            blk_d   = '0;
            phase_d = 1'b1;
            dir_d   = 1'b0;
            case (mode_d)
                MODE_OFF:     level_d = 8'd0;
                MODE_SOLID:   level_d = FULL;
                MODE_BLINK:   level_d = FULL;
                MODE_BREATHE: level_d = 8'd0;
            endcase
        end else begin
            case (mode_q)
                MODE_OFF:   level_d = 8'd0;
                MODE_SOLID: level_d = FULL;
                MODE_BLINK: begin
                    if (tick_w) begin
                        if (blk_q == BLK_W'(BLINK_TICKS - 1)) begin
                            blk_d   = '0;
                            phase_d = !phase_q;
                        end else begin
                            blk_d = blk_q + BLK_W'(1);
                        end
                    end
                    level_d = phase_d ? FULL : 8'd0;
                end
                MODE_BREATHE: begin
                    // Clamp at the ends so 255 and 0 are always hit exactly.
                    if (tick_w) begin
                        if (!dir_q) begin
                            if (level_q >= (FULL - STEP_B)) begin
                                level_d = FULL;
                                dir_d   = 1'b1;
                            end else begin
                                level_d = level_q + STEP_B;
                            end
                        end else begin
                            if (level_q <= STEP_B) begin
                                level_d = 8'd0;
                                dir_d   = 1'b0;
                            end else begin
                                level_d = level_q - STEP_B;
                            end
                        end
                    end
                end
            endcase
        end

        color_d = {scale(base_color[23:16], level_q),
                   scale(base_color[15:8],  level_q),
                   scale(base_color[7:0],   level_q)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_OFF;
            cnt_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            dir_q   <= 1'b0;
            level_q <= 8'd0;
            color_q <= 24'd0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            color_q <= color_d;
        end
    end

    assign color_out = color_q;
    assign level     = level_q;
    assign tick      = tick_w;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Upstream colour source for the WS2812B serializer; drives its 24-bit GRB colour input.
- Produces status-LED effects from a base GRB colour and a mode select: off, solid, blink, breathe.
  - Blink is a square-wave on/off.
  - Breathe is a triangular brightness ramp.
- Output is a registered, brightness-scaled GRB word. The serializer re-latches it at each frame start, so the output may change at any cycle.

Parameters:
- CLK_HZ, 27000000, input clock frequency in Hz.
- TICK_HZ, 1000, effect update rate. DIV = CLK_HZ/TICK_HZ must be an integer >= 2.
- BLINK_TICKS, 250, ticks per blink half-period (on time = off time).
- STEP, 2, breathe level increment/decrement per tick, range 1..255.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- mode, input, 2, effect select: 0=OFF, 1=SOLID, 2=BLINK, 3=BREATHE.
- base_color, input, 24, GRB colour: [23:16]=G, [15:8]=R, [7:0]=B.
- color_out, output, 24, scaled GRB colour to the serializer.
- level, output, 8, current brightness level, 0..255.
- tick, output, 1, one-cycle pulse marking each effect update.

Behaviour:
- Reset is asynchronous, active-high, and may be asserted at any time, including mid-ramp. While rst=1 and on the first cycle after release:
  - color_out=0, level=0, tick=0.
  - Prescaler count=0, blink counter=0, blink phase=0, breathe dir=UP.
  - mode_q=OFF.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick=1 in exactly the cycle where count==DIV-1; otherwise tick=0.
  - Period is DIV cycles.
- Mode capture:
  - mode_q <= mode every cycle.
  - When mode != mode_q (a change), in that same cycle:
    - Prescaler, blink counter, blink phase and dir restart (count=0, blink counter=0, phase=ON, dir=UP).
    - level is loaded with the new mode's initial value: OFF=0, SOLID=255, BLINK=255, BREATHE=0.
    - tick is suppressed in the change cycle.
- Level update per mode (registered; applies only on tick cycles unless noted):
  - OFF: level=0 every cycle.
  - SOLID: level=255 every cycle.
  - BLINK:
    - On each tick the blink counter increments.
    - When the blink counter reaches BLINK_TICKS-1, it wraps to 0 and the phase toggles.
    - level=255 when phase=ON, otherwise 0.
    - The first toggle to OFF occurs on the BLINK_TICKS-th tick after mode entry.
  - BREATHE:
    - dir=UP: if level >= 255-STEP, then level=255 and dir=DOWN; else level += STEP.
    - dir=DOWN: if level <= STEP, then level=0 and dir=UP; else level -= STEP.
    - Never wraps; 255 and 0 are always hit exactly and each is held for one tick.
- Scaling:
  - Each channel c is computed as (c * level) >> 8, an 8x8 unsigned multiply keeping product bits [15:8].
  - Special case: level=255 passes the channel through unchanged, so full brightness is exact.
  - color_out is registered, with latency 1 cycle from level or base_color.
  - base_color is not latched; a change appears on color_out after 1 cycle.
- Boundary cases:
  - A mode change coinciding with a tick: the mode change wins and no level step is taken.
  - Re-selecting the same mode is not a change and causes no restart.
  - An illegal DIV is a parameter error and is not handled at runtime.

Test Plan:
- Tick period: CLK_HZ=1000, TICK_HZ=100, reset released → tick pulses every 10 cycles, each 1 cycle wide. The first tick occurs on the 10th cycle after reset release.
- Solid scaling: mode=1, base_color=24'h80FF40 → level=255 and color_out=24'h80FF40 two cycles after the mode change. With mode=0 → color_out=0 within 2 cycles.
- Blink: BLINK_TICKS=3, mode=2, base=24'h0000FF → color_out alternates 24'h0000FF / 0, each phase 3 ticks (30 cycles). The first OFF begins after the 3rd tick.
- Breathe: STEP=64, mode=3, base=24'hFFFFFF → level sequence 0, 64, 128, 192, 255, 191, 127, 63, 0, 64. At level=128, color_out=24'h7F7F7F.
- Mode change mid-ramp: BREATHE at level=128 (dir=UP), switch to BLINK in a tick cycle → level=255, phase=ON, no tick in that cycle, and the prescaler restarts from 0.
- Async reset mid-operation: assert rst between clock edges during BLINK → color_out and level become 0 immediately, without waiting for a clock edge. After release the block stays OFF until mode differs from 0.
